// File: rtl/qei_gen_if.sv
// Command channel of the quadrature edge generator.
// The bench drives the master side; the generator is the slave.
interface qei_gen_if #(
  parameter int unsigned nbits = 16,
  parameter int unsigned pbits = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [nbits-1:0] cmd_steps;
  logic        [pbits-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/qei_gen.sv
// Quadrature encoder signal generator.
// Emits a signed number of A/B transitions, one every cmd_period cycles, and tracks the position.
module qei_gen #(
  parameter int unsigned nbits = 16,
  parameter int unsigned pbits = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             abort,
  qei_gen_if.slave         cmd,
  output logic             A_o,
  output logic             B_o,
  output logic             busy,
  output logic             done,
  output logic [nbits-1:0] pos_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  logic [pbits-1:0] r_cnt;
  logic [pbits-1:0] r_per;
  logic [nbits-1:0] r_rem;
  logic [nbits-1:0] r_pos;
  logic             r_dir;
  logic             r_a;
  logic             r_b;
  logic             r_done;

  logic             w_hs;
  logic [pbits-1:0] w_per;
  logic [nbits-1:0] w_mag;
  logic             w_edge;

  assign w_hs  = cmd.cmd_valid && cmd.cmd_ready;
  assign w_per = (cmd.cmd_period == '0) ? pbits'(1) : cmd.cmd_period;
  // Unsigned magnitude: the most negative command maps to 2^(nbits-1) edges.
  assign w_mag = cmd.cmd_steps[nbits-1] ? (~cmd.cmd_steps + nbits'(1)) : cmd.cmd_steps;
  // A same-cycle abort suppresses the edge that would otherwise be due.
  assign w_edge = (r_state == StRun) && en && !abort && (r_cnt == pbits'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_per   <= '0;
      r_rem   <= '0;
      r_pos   <= '0;
      r_dir   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (clr) begin
        r_pos <= '0;
      end else if (w_edge) begin
        r_pos <= r_dir ? (r_pos - nbits'(1)) : (r_pos + nbits'(1));
      end

      // Forward walks 00->10->11->01, reverse walks it backwards.
      if (w_edge) begin
        r_a <= r_dir ? r_b  : ~r_b;
        r_b <= r_dir ? ~r_a : r_a;
      end

      unique case (r_state)
        StIdle: begin
          if (w_hs) begin
            r_per <= w_per;
            r_cnt <= w_per;
            r_rem <= w_mag;
            r_dir <= cmd.cmd_steps[nbits-1];
            if (w_mag == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (abort) begin
            r_state <= StIdle;
          end else if (en) begin
            if (w_edge) begin
              r_rem <= r_rem - nbits'(1);
              r_cnt <= r_per;
              if (r_rem == nbits'(1)) begin
                r_state <= StIdle;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - pbits'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Ready is held off during the completion pulse so it rises the cycle after.
  assign cmd.cmd_ready = (r_state == StIdle) && !r_done;
  assign busy          = (r_state == StRun);
  assign done          = r_done;
  assign A_o           = r_a;
  assign B_o           = r_b;
  assign pos_o         = r_pos;

endmodule

// File: tb/tb_qei_gen.sv
// Directed and randomized checks of qei_gen against a phase/position model and a
// quadrature decoder fed from A_o/B_o.
module tb_qei_gen;
  localparam int unsigned NB = 16;
  localparam int unsigned PB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          en = 1'b1;
  logic          abort = 1'b0;
  logic          A_o, B_o, busy, done;
  logic [NB-1:0] pos_o;

  int n_chk = 0;
  int n_err = 0;

  qei_gen_if #(.nbits(NB), .pbits(PB)) cmd_if ();

  qei_gen #(.nbits(NB), .pbits(PB)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .abort(abort),
    .cmd  (cmd_if),
    .A_o  (A_o),
    .B_o  (B_o),
    .busy (busy),
    .done (done),
    .pos_o(pos_o)
  );

  always #5 clk = ~clk;

  // Phase index along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic int ab_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int qdiff(input int from_i, input int to_i);
    return (to_i - from_i + 4) % 4;
  endfunction

  // Reference quadrature decoder, one cycle behind the outputs.
  logic [NB-1:0] dec_cnt;
  int            dec_bad;
  logic          dec_a, dec_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
      dec_bad <= 0;
      dec_a   <= 1'b0;
      dec_b   <= 1'b0;
    end else begin
      dec_a <= A_o;
      dec_b <= B_o;
      case (qdiff(ab_idx(dec_a, dec_b), ab_idx(A_o, B_o)))
        1:       dec_cnt <= dec_cnt + 16'd1;
        3:       dec_cnt <= dec_cnt - 16'd1;
        2:       dec_bad <= dec_bad + 1;
        default: ;
      endcase
    end
  end

  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns with the handshake edge just past; command inputs are then scrambled.
  task automatic send(input int s, input int p);
    int w;
    w = 0;
    while (!cmd_if.cmd_ready && w < 50) begin
      step();
      w++;
    end
    chk("ready_wait", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_steps  = s[NB-1:0];
    cmd_if.cmd_period = p[PB-1:0];
    step();
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_steps  = NB'($urandom);
    cmd_if.cmd_period = PB'($urandom);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            s, p, mag, eff, cyc, budget, ph;
    logic [NB-1:0] exp_pos;
    logic          saw_done;

    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_steps  = '0;
    cmd_if.cmd_period = '0;

    // Reset values
    step();
    step();
    chk("rst_ab", 32'({A_o, B_o}), 32'h0);
    chk("rst_pos", 32'(pos_o), 32'h0);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();

    // Forward: 4 steps, period 3
    send(4, 3);
    chk("fwd_busy0", 32'(busy), 32'd1);
    chk("fwd_ready0", 32'(cmd_if.cmd_ready), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("fwd_ab", 32'({A_o, B_o}), 32'(ab_tab[(c / 3) % 4]));
      chk("fwd_done", 32'(done), 32'(c == 12));
    end
    chk("fwd_pos", 32'(pos_o), 32'd4);
    chk("fwd_busy_end", 32'(busy), 32'd0);
    step();
    chk("fwd_ready_after", 32'(cmd_if.cmd_ready), 32'd1);
    chk("fwd_done_after", 32'(done), 32'd0);

    // Reverse wrap: -2 steps, period 1
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_pos", 32'(pos_o), 32'h0);
    send(-2, 1);
    step();
    chk("rev_ab1", 32'({A_o, B_o}), 32'h1);
    chk("rev_pos1", 32'(pos_o), 32'hFFFF);
    chk("rev_done1", 32'(done), 32'd0);
    step();
    chk("rev_ab2", 32'({A_o, B_o}), 32'h3);
    chk("rev_pos2", 32'(pos_o), 32'hFFFE);
    chk("rev_done2", 32'(done), 32'd1);

    // Zero steps
    send(0, 5);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_ab", 32'({A_o, B_o}), 32'h3);
    step();
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_pos", 32'(pos_o), 32'hFFFE);

    // One step with period 0
    send(1, 0);
    chk("p0_done0", 32'(done), 32'd0);
    step();
    chk("p0_ab", 32'({A_o, B_o}), 32'h1);
    chk("p0_done", 32'(done), 32'd1);
    chk("p0_pos", 32'(pos_o), 32'hFFFF);

    // Abort after three edges; the fourth is due on the abort edge
    clr = 1'b1;
    step();
    clr = 1'b0;
    send(10, 2);
    for (int c = 1; c <= 7; c++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_done", 32'(done), 32'd0);
    chk("abt_ab", 32'({A_o, B_o}), 32'h3);
    chk("abt_pos", 32'(pos_o), 32'd3);
    chk("abt_ready", 32'(cmd_if.cmd_ready), 32'd1);
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      saw_done = saw_done | done;
    end
    chk("abt_no_done", 32'(saw_done), 32'd0);
    chk("abt_ab_hold", 32'({A_o, B_o}), 32'h3);

    // en low for 5 cycles between the two edges; clr lands on the last edge
    send(2, 4);
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 4) begin
        chk("en_ab1", 32'({A_o, B_o}), 32'h1);
        chk("en_pos1", 32'(pos_o), 32'd4);
      end
      if (c == 8 || c == 12) chk("en_ab_hold", 32'({A_o, B_o}), 32'h1);
      if (c == 12) chk("en_busy", 32'(busy), 32'd1);
      if (c == 5) en = 1'b0;
      if (c == 10) en = 1'b1;
      if (c == 12) clr = 1'b1;
    end
    clr = 1'b0;
    chk("en_ab2", 32'({A_o, B_o}), 32'h0);
    chk("en_done", 32'(done), 32'd1);
    chk("en_clr_pos", 32'(pos_o), 32'd0);
    step();

    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abt_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("idle_abt_busy", 32'(busy), 32'd0);

    // Reset in the middle of a command
    send(5, 2);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ab", 32'({A_o, B_o}), 32'h0);
    chk("mid_rst_pos", 32'(pos_o), 32'h0);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      saw_done = saw_done | done;
    end
    chk("mid_rst_no_done", 32'(saw_done), 32'd0);
    chk("mid_rst_ab_hold", 32'({A_o, B_o}), 32'h0);

    // Random commands checked against the model and the decoder
    exp_pos = '0;
    ph = 0;
    for (int n = 0; n < 24; n++) begin
      s = int'($urandom_range(0, 60)) - 30;
      p = int'($urandom_range(0, 3));
      mag = (s < 0) ? -s : s;
      eff = (p == 0) ? 1 : p;
      budget = mag * eff + 4;
      send(s, p);
      cyc = 0;
      while (!done && cyc < budget) begin
        step();
        cyc++;
      end
      chk("rnd_latency", 32'(cyc), 32'(mag * eff));
      exp_pos = exp_pos + NB'(s);
      ph = ((ph + s) % 4 + 4) % 4;
      chk("rnd_pos", 32'(pos_o), 32'(exp_pos));
      chk("rnd_ab", 32'({A_o, B_o}), 32'(ab_tab[ph]));
      chk("rnd_busy", 32'(busy), 32'd0);
      step();
      chk("rnd_decoder", 32'(dec_cnt), 32'(exp_pos));
    end
    chk("decoder_no_skips", 32'(dec_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/qei_gen.md
QEI_GEN -- requirements
Module: qei_gen

Interface
REQ-001 Parameter nbits, default 16, width of step command and position counter.
REQ-002 Parameter pbits, default 16, width of the edge-period command.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear of pos_o only.
REQ-006 en  input  1  enable; low freezes the period counter and edge generation.
REQ-007 abort  input  1  synchronous abort of the command in progress.
REQ-008 cmd_valid  input  1  command offered.
REQ-009 cmd_ready  output  1  block can accept a command (high only in IDLE).
REQ-010 cmd_steps  input  nbits  signed two's-complement edge count; positive is forward.
REQ-011 cmd_period  input  pbits  clk cycles between successive edges; 0 is treated as 1.
REQ-012 A_o  output  1  quadrature channel A, registered.
REQ-013 B_o  output  1  quadrature channel B, registered.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle pulse when a command completes normally.
REQ-016 pos_o  output  nbits  signed position, one count per emitted edge.

Function
REQ-017 Each emitted edge is one quadrature transition, so that a matching decoder counts exactly one per edge.
- Forward (A,B) sequence: 00 -> 10 -> 11 -> 01 -> 00.
- Reverse sequence: 00 -> 01 -> 11 -> 10 -> 00.
REQ-018 Only one of A_o/B_o SHALL change per edge, and edges SHALL be at least one clk apart.
REQ-019 FSM states SHALL be IDLE and RUN.
- Handshake completes in a cycle when cmd_valid && cmd_ready.
- On handshake, steps/direction/period are latched; later input changes have no effect on the running command.
REQ-020 Handshake with cmd_steps == 0:
- stay in IDLE;
- pulse done in the next cycle;
- emit no edge.
REQ-021 Handshake with cmd_steps != 0:
- enter RUN next cycle;
- remaining count = |cmd_steps| as nbits-bit unsigned, so -2^(nbits-1) yields 2^(nbits-1) edges;
- period counter loaded with max(cmd_period,1).
REQ-022 In RUN with en high, the period counter decrements each cycle; on reaching expiry:
- one edge is emitted;
- remaining is decremented;
- the counter is reloaded.
- First edge is visible on A_o/B_o exactly P cycles after the handshake cycle (P = effective period).
- Subsequent edges follow every P cycles.
REQ-023 When the last edge is emitted, the FSM SHALL return to IDLE and done SHALL pulse in the same cycle the last edge appears on A_o/B_o.
- cmd_ready rises the following cycle.
REQ-024 With en low, the counter, outputs and FSM hold their values; the handshake is still accepted in IDLE.
REQ-025 pos_o SHALL change in the same cycle as each edge:
- +1 forward, -1 reverse;
- wraps modulo 2^nbits with no saturation.
REQ-026 clr zeroes pos_o next cycle and has priority over a simultaneous edge increment; it does not affect the FSM, A_o or B_o.
REQ-027 abort in RUN returns the FSM to IDLE next cycle.
- No further edge is emitted and done is not pulsed.
- An edge due in the same cycle as abort is suppressed.
- abort in IDLE is ignored.
REQ-028 A_o/B_o SHALL retain their phase between commands; a new command continues the sequence from the current phase.
REQ-029 done and busy SHALL never be high in the same cycle except the completion cycle of REQ-023, where busy is already low.

Reset
REQ-030 While rst is high, registers take these values:
- A_o=0, B_o=0, pos_o=0;
- FSM=IDLE, cmd_ready=1, busy=0, done=0;
- counters=0.
REQ-031 rst asserted mid-RUN SHALL abort immediately, with no done pulse after release.

Verification
REQ-032 Forward: steps=4, period=3 -> (A,B)=10,11,01,00 at cycles 3,6,9,12 after handshake; pos_o=4; done at cycle 12.
REQ-033 Reverse wrap: pos_o=0, steps=-2, period=1 -> (A,B)=01 then 11 on consecutive cycles; pos_o=0xFFFF then 0xFFFE.
REQ-034 Zero/period-zero:
- steps=0 -> done one cycle later, no edge.
- steps=1, period=0 -> edge one cycle after handshake.
REQ-035 Abort: steps=10, period=2, abort after 3 edges -> exactly 3 edges, pos_o=3, no done, cmd_ready high next cycle.
REQ-036 en low for 5 cycles mid-RUN (steps=2, period=4) -> second edge delayed by exactly 5 cycles; clr concurrent with an edge -> pos_o=0.
REQ-037 Loopback into the team's quadrature decoder: random signed commands and periods -> decoder count equals pos_o after every done.
